// File: rtl/cmd_uart_wrapper.sv
// UART command front end: assembles three 8N1 bytes into a 24-bit command word
// and transmits single response bytes, with RX and TX running independently.
module cmd_uart_wrapper #(
  parameter int BAUD_DIV = 1302
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  localparam logic [11:0] BAUD_FULL = 12'(BAUD_DIV - 1);
  localparam logic [11:0] BAUD_HALF = 12'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

  rx_state_t   rx_state;
  tx_state_t   tx_state;
  logic        rx_meta, rx_sync, rx_prev;
  logic [11:0] rx_cnt, tx_cnt;
  logic [2:0]  rx_bits;
  logic [7:0]  rx_shift;
  logic [1:0]  byte_cnt;
  logic [9:0]  tx_shift;
  logic [3:0]  tx_bits;

  // rx_prev holds the previous synchronized level so a start edge is seen only after sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      byte_cnt <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
    end else begin
      if (clr_cmd_rdy)
        cmd_rdy <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= BAUD_HALF;
          end
        end
        RX_START: begin
          if (rx_cnt == 12'd0) begin
            rx_cnt  <= BAUD_FULL;
            rx_bits <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt - 12'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == 12'd0) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_cnt   <= BAUD_FULL;
            if (rx_bits == 3'd7)
              rx_state <= RX_STOP;
            else
              rx_bits <= rx_bits + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 12'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == 12'd0) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= BAUD_FULL;
            // Bytes arriving while a command is still pending are dropped outright
            if (!rx_sync) begin
              byte_cnt <= '0;
            end else if (!cmd_rdy) begin
              case (byte_cnt)
                2'd0: begin
                  cmd[23:16] <= rx_shift;
                  byte_cnt   <= 2'd1;
                end
                2'd1: begin
                  cmd[15:8] <= rx_shift;
                  byte_cnt  <= 2'd2;
                end
                default: begin
                  cmd[7:0] <= rx_shift;
                  cmd_rdy  <= 1'b1;
                  byte_cnt <= 2'd0;
                end
              endcase
            end
          end else begin
            rx_cnt <= rx_cnt - 12'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // TX is the LSB of the shift register, which idles all ones and fills with ones
  assign TX = tx_shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_shift  <= '1;
      tx_cnt    <= '0;
      tx_bits   <= '0;
      tx_busy   <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      resp_sent <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_shift <= {1'b1, resp_data, 1'b0};
            tx_cnt   <= BAUD_FULL;
            tx_bits  <= '0;
            tx_busy  <= 1'b1;
            tx_state <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_cnt == 12'd0) begin
            tx_cnt <= BAUD_FULL;
            if (tx_bits == 4'd9) begin
              tx_state  <= TX_IDLE;
              tx_busy   <= 1'b0;
              resp_sent <= 1'b1;
              tx_shift  <= '1;
            end else begin
              tx_shift <= {1'b1, tx_shift[9:1]};
              tx_bits  <= tx_bits + 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 12'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Bench for cmd_uart_wrapper: directed and random UART traffic against a
// queue-based command model and a frame-table TX model.
module tb_cmd_uart_wrapper;
  localparam int BAUD = 8;

  logic        clk = 1'b0;
  logic        rst_n, RX, clr_cmd_rdy, send_resp;
  logic [7:0]  resp_data;
  logic        TX, cmd_rdy, resp_sent, tx_busy;
  logic [23:0] cmd;

  int total = 0;
  int bad = 0;

  logic [7:0]  exp_q[$];
  logic        exp_rdy = 1'b0;
  logic [23:0] exp_cmd = '0;

  cmd_uart_wrapper #(.BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data), .send_resp(send_resp),
    .resp_sent(resp_sent), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model: accepted bytes queue up; three of them make a command
  task automatic model_byte(input logic [7:0] data, input logic stop_ok);
    if (!stop_ok) begin
      exp_q.delete();
    end else if (!exp_rdy) begin
      exp_q.push_back(data);
      if (exp_q.size() == 3) begin
        exp_cmd = {exp_q[0], exp_q[1], exp_q[2]};
        exp_rdy = 1'b1;
        exp_q.delete();
      end
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int k = 0; k < 10; k++) begin
      RX = frame[k];
      repeat (BAUD) @(negedge clk);
    end
    RX = 1'b1;
    repeat (4) @(negedge clk);
    model_byte(data, stop_bit);
    check_output("cmd_rdy", 32'(cmd_rdy), 32'(exp_rdy));
    if (exp_rdy)
      check_output("cmd", 32'(cmd), 32'(exp_cmd));
  endtask

  task automatic clr_pulse();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
    @(negedge clk);
    check_output("cmd_rdy_clr", 32'(cmd_rdy), 32'(exp_rdy));
  endtask

  task automatic glitch();
    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (16) @(negedge clk);
    check_output("glitch_rdy", 32'(cmd_rdy), 32'(exp_rdy));
  endtask

  task automatic tx_check(input logic [7:0] data, input logic inject);
    logic [9:0] frame;
    int sent_cnt;
    frame = {1'b1, data, 1'b0};
    sent_cnt = 0;
    resp_data = data;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    resp_data = 8'($urandom);
    for (int idx = 0; idx < 80; idx++) begin
      if ((idx % 8 == 0) || (idx % 8 == 7))
        check_output($sformatf("tx_bit%0d_c%0d", idx / 8, idx), 32'(TX), 32'(frame[idx / 8]));
      if (idx == 0 || idx == 79)
        check_output("tx_busy_on", 32'(tx_busy), 32'd1);
      if (resp_sent)
        sent_cnt++;
      if (inject && idx == 20) begin
        send_resp = 1'b1;
        resp_data = ~data;
      end else begin
        send_resp = 1'b0;
      end
      @(negedge clk);
    end
    check_output("resp_early", 32'(sent_cnt), 32'd0);
    check_output("resp_sent", 32'(resp_sent), 32'd1);
    check_output("tx_busy_off", 32'(tx_busy), 32'd0);
    check_output("tx_idle", 32'(TX), 32'd1);
    @(negedge clk);
    check_output("resp_once", 32'(resp_sent), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp_data = '0;
    repeat (3) @(negedge clk);
    check_output("rst_tx", 32'(TX), 32'd1);
    check_output("rst_cmd", 32'(cmd), 32'd0);
    check_output("rst_rdy", 32'(cmd_rdy), 32'd0);
    check_output("rst_sent", 32'(resp_sent), 32'd0);
    check_output("rst_busy", 32'(tx_busy), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic command and hold until cleared
    apply_stimulus(8'h12, 1'b1);
    apply_stimulus(8'h34, 1'b1);
    apply_stimulus(8'h56, 1'b1);
    repeat (20) @(negedge clk);
    check_output("rdy_hold", 32'(cmd_rdy), 32'(exp_rdy));
    clr_pulse();
    clr_pulse();

    // Bytes during a pending command are dropped
    apply_stimulus(8'h12, 1'b1);
    apply_stimulus(8'h34, 1'b1);
    apply_stimulus(8'h56, 1'b1);
    apply_stimulus(8'hAA, 1'b1);
    apply_stimulus(8'hBB, 1'b1);
    apply_stimulus(8'hCC, 1'b1);
    clr_pulse();
    apply_stimulus(8'h01, 1'b1);
    apply_stimulus(8'h02, 1'b1);
    apply_stimulus(8'h03, 1'b1);
    clr_pulse();

    // Framing error discards partial command
    apply_stimulus(8'h12, 1'b1);
    apply_stimulus(8'h34, 1'b0);
    apply_stimulus(8'h56, 1'b1);
    apply_stimulus(8'h78, 1'b1);
    apply_stimulus(8'h9A, 1'b1);
    clr_pulse();

    // Start-bit glitch leaves the byte counter alone
    apply_stimulus(8'h12, 1'b1);
    glitch();
    apply_stimulus(8'h34, 1'b1);
    apply_stimulus(8'h56, 1'b1);
    clr_pulse();

    // Response transmit with an ignored second request
    tx_check(8'hA5, 1'b1);

    // RX and TX concurrently
    fork
      tx_check(8'h3C, 1'b0);
      begin
        apply_stimulus(8'hDE, 1'b1);
        apply_stimulus(8'hAD, 1'b1);
        apply_stimulus(8'h42, 1'b1);
      end
    join
    clr_pulse();

    // Random traffic against the model
    for (int n = 0; n < 10; n++) begin
      apply_stimulus(8'($urandom), ($urandom_range(0, 5) != 0));
      if ($urandom_range(0, 2) == 0)
        clr_pulse();
    end
    clr_pulse();
    tx_check(8'($urandom), 1'($urandom_range(0, 1)));

    // Reset mid-frame on both directions
    exp_q.delete();
    apply_stimulus(8'h11, 1'b1);
    resp_data = 8'h77;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    RX = 1'b0;
    repeat (12) @(negedge clk);
    RX = 1'b1;
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_output("mid_rst_tx", 32'(TX), 32'd1);
    check_output("mid_rst_busy", 32'(tx_busy), 32'd0);
    check_output("mid_rst_rdy", 32'(cmd_rdy), 32'd0);
    check_output("mid_rst_cmd", 32'(cmd), 32'd0);
    exp_q.delete();
    exp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("post_rst_tx", 32'(TX), 32'd1);
    check_output("post_rst_busy", 32'(tx_busy), 32'd0);
    apply_stimulus(8'hC0, 1'b1);
    apply_stimulus(8'hFF, 1'b1);
    apply_stimulus(8'hEE, 1'b1);
    clr_pulse();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmd_uart_wrapper.md
CMD_UART_WRAPPER -- requirements
Module: cmd_uart_wrapper

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 1302, meaning clk cycles per UART bit; legal range 8..4095.
REQ-002 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port RX, input, 1, serial command line from host, idle high, asynchronous to clk.
REQ-005 SHALL have port TX, output, 1, serial response line to host, idle high.
REQ-006 SHALL have port cmd, output, 24, the assembled command word.
REQ-007 SHALL have port cmd_rdy, output, 1, meaning cmd holds a complete unconsumed command.
REQ-008 SHALL have port clr_cmd_rdy, input, 1, a one-cycle pulse from the command consumer that clears cmd_rdy.
REQ-009 SHALL have port resp_data, input, 8, the response byte to transmit.
REQ-010 SHALL have port send_resp, input, 1, a one-cycle pulse requesting transmission of resp_data.
REQ-011 SHALL have port resp_sent, output, 1, a one-cycle pulse marking response transmission complete.
REQ-012 SHALL have port tx_busy, output, 1, high while a TX frame is in progress.

Function
REQ-013 Frame format SHALL be 8N1, LSB first, on both RX and TX.
REQ-014 RX SHALL pass through a 2-flop synchronizer (flops reset to 1) before any use.
REQ-015 RX FSM SHALL use states IDLE, START, DATA, STOP.
REQ-016 IDLE->START SHALL occur on a synchronized 1->0 transition.
REQ-017 START SHALL re-sample at BAUD_DIV/2 cycles; a 1 there SHALL return to IDLE as a glitch, with no byte.
REQ-018 DATA SHALL sample 8 bits, each BAUD_DIV cycles after the previous sample; the shift register SHALL shift right and insert at bit 7.
REQ-019 STOP SHALL sample BAUD_DIV cycles after bit 7; a 1 completes the byte, a 0 is a framing error that discards the byte; both SHALL return to IDLE.
REQ-020 Command bytes SHALL be assembled MSB first: byte0->cmd[23:16], byte1->cmd[15:8], byte2->cmd[7:0].
REQ-021 A 2-bit byte counter SHALL advance only on completed bytes and wrap 2->0.
REQ-022 cmd_rdy SHALL rise the cycle after byte2's stop-bit sample and hold until clr_cmd_rdy.
REQ-023 cmd SHALL be stable whenever cmd_rdy=1.
REQ-024 Bytes completing while registered cmd_rdy=1 SHALL be dropped and SHALL NOT advance the counter, including the byte completing in the same cycle clr_cmd_rdy is asserted.
REQ-025 clr_cmd_rdy while cmd_rdy=0 SHALL have no effect.
REQ-026 A framing error SHALL reset the byte counter to 0, discarding any partial command.
REQ-027 TX FSM SHALL use states IDLE and XMIT, with a 10-bit shift register {1, data, 0} and a 4-bit bit counter.
REQ-028 send_resp in IDLE SHALL latch resp_data and drive TX low on the next cycle; tx_busy SHALL rise in the same cycle.
REQ-029 Each TX bit SHALL be held exactly BAUD_DIV cycles.
REQ-030 After the stop bit's BAUD_DIV cycles, the FSM SHALL return to IDLE, pulse resp_sent for one cycle, and drop tx_busy.
REQ-031 send_resp while tx_busy=1 SHALL be ignored; the in-flight byte SHALL be unaffected.
REQ-032 RX and TX SHALL operate fully independently and concurrently.
REQ-033 Baud counters SHALL be wide enough for 4095 and SHALL reload on every state entry.

Reset
REQ-034 While rst_n=0: TX=1, cmd=0, cmd_rdy=0, resp_sent=0, tx_busy=0, both FSMs in IDLE, byte counter=0.
REQ-035 Reset asserted mid-frame SHALL abort both frames immediately; the partial command and pending response SHALL be lost.
REQ-036 After rst_n rises, the first valid start bit SHALL be accepted normally.

Verification (BAUD_DIV=8)
REQ-037 Send RX bytes 0x12, 0x34, 0x56 -> cmd=0x123456, cmd_rdy=1 one cycle after the third stop sample; cmd_rdy stays 1 until clr_cmd_rdy is pulsed, then 0.
REQ-038 With cmd_rdy=1, send 0xAA, 0xBB, 0xCC, then clr, then 0x01, 0x02, 0x03 -> cmd=0x010203; the AA/BB/CC bytes are dropped.
REQ-039 Send 0x12, then 0x34 with stop bit=0, then 0x56, 0x78, 0x9A -> cmd=0x56789A, with no cmd_rdy before the 0x9A byte.
REQ-040 Pulse send_resp with resp_data=0xA5 -> TX=0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; resp_sent pulses once at cycle 80 after tx start; a second send_resp at cycle 20 is ignored.
REQ-041 RX 3-cycle low glitch -> no byte and no counter change.
REQ-042 Assert rst_n=0 mid-TX and mid-RX after byte1 -> TX=1 immediately; after release, a fresh 3-byte command assembles correctly.
